ddr_burst_sched: RTL and testbench

Parametrised N-channel DDR2 burst scheduler. It sits between per-channel video FIFOs and the `mem_burst_ddr` burst engine. It arbitrates write and read bursts round-robin and generates per-channel frame addresses with double buffering (ping-pong), so a read frame never tears against a write frame. It also emits per-channel frame-done pulses.

---
 rtl/ddr_burst_sched.sv | 207 ++++++++++++++++++++
 tb/tb_ddr_burst_sched.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ddr_burst_sched.sv
// ddr_burst_sched
// Round-robin DDR2 burst scheduler for CH_NUM video channels. Write and read
// bursts from all channels compete as 2*CH_NUM slots (slot = 2*ch + dir).
// Frame addresses are double buffered, so a read frame always comes from the
// buffer that is not currently being written.
// Ports:
//   phy_clk, rst                      clock, async active-high reset
//   init_done                         DDR calibrated; gates new grants
//   wr_req/rd_req/frame_restart       per-channel FIFO levels and vsync
//   wr_burst_* / rd_burst_*           burst engine handshake
//   wr_fifo_rd_en/rd_fifo_wr_en       engine strobes routed to granted channel
//   wr_frame_done/rd_frame_done       one-cycle frame completion pulses
//   ready                             idle and calibrated
module ddr_burst_sched #(
  parameter int CH_NUM      = 4,
  parameter int CH_W        = 2,
  parameter int ADDR_W      = 25,
  parameter int OFS_W       = 21,
  parameter int LEN_W       = 10,
  parameter int FRAME_WORDS = 245760,
  parameter int BURST_LEN   = 256
) (
  input  logic              phy_clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic [CH_NUM-1:0] wr_req,
  input  logic [CH_NUM-1:0] rd_req,
  input  logic [CH_NUM-1:0] frame_restart,
  output logic              wr_burst_req,
  output logic [ADDR_W-1:0] wr_burst_addr,
  output logic [LEN_W-1:0]  wr_burst_len,
  input  logic              wr_burst_data_req,
  input  logic              wr_burst_finish,
  output logic              rd_burst_req,
  output logic [ADDR_W-1:0] rd_burst_addr,
  output logic [LEN_W-1:0]  rd_burst_len,
  input  logic              rd_burst_data_valid,
  input  logic              rd_burst_finish,
  output logic [CH_NUM-1:0] wr_fifo_rd_en,
  output logic [CH_NUM-1:0] rd_fifo_wr_en,
  output logic [CH_NUM-1:0] wr_frame_done,
  output logic [CH_NUM-1:0] rd_frame_done,
  output logic              ready
);
  localparam int NS = 2 * CH_NUM;
  localparam int SW = CH_W + 1;
  localparam logic [OFS_W-1:0] OFS_STEP = OFS_W'(BURST_LEN);
  localparam logic [OFS_W-1:0] OFS_LAST = OFS_W'(FRAME_WORDS - BURST_LEN);

  typedef enum logic [1:0] {IDLE, WR_BUSY, RD_BUSY} state_t;
  state_t state, state_nx;

  logic [SW-1:0] rr, gnt_slot, sel_slot, idx;
  logic          sel_vld, grant, finish, busy, gnt_rd;
  logic [CH_W-1:0] gnt_ch, sel_ch;
  logic [NS-1:0] slot_req;
  logic [CH_NUM-1:0][OFS_W-1:0] wr_ofs, rd_ofs;
  logic [CH_NUM-1:0] wr_buf, rd_buf, frm_valid, pending;
  logic [OFS_W-1:0] sel_wofs, sel_rofs;
  logic             sel_rbuf;

  function automatic logic [ADDR_W-1:0] mk_addr(input logic [CH_W-1:0] ch,
                                                input logic b,
                                                input logic [OFS_W-1:0] ofs);
    logic [ADDR_W-1:0] a;
    a = '0;
    a[OFS_W-1:0]       = ofs;
    a[OFS_W]           = b;
    a[OFS_W+1 +: CH_W] = ch;
    return a;
  endfunction

  assign busy   = (state != IDLE);
  assign gnt_ch = gnt_slot[SW-1:1];
  assign gnt_rd = gnt_slot[0];
  assign sel_ch = sel_slot[SW-1:1];
  assign ready  = init_done && (state == IDLE);

  // Reads stay masked until the channel has a complete frame in memory.
  always_comb begin
    slot_req = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      slot_req[2*c]   = wr_req[c];
      slot_req[2*c+1] = rd_req[c] & frm_valid[c];
    end
  end

  // Round-robin search beginning one slot past the last grant.
  always_comb begin
    sel_vld  = 1'b0;
    sel_slot = '0;
    idx      = '0;
    for (int i = 1; i <= NS; i++) begin
      idx = SW'((int'(rr) + i) % NS);
      if (!sel_vld && slot_req[idx]) begin
        sel_vld  = 1'b1;
        sel_slot = idx;
      end
    end
  end

  // A restart still pending at grant time takes effect on this very edge,
  // so the granted address must already see offset 0.
  always_comb begin
    sel_wofs = pending[sel_ch] ? '0 : wr_ofs[sel_ch];
    sel_rofs = pending[sel_ch] ? '0 : rd_ofs[sel_ch];
    // A new read frame locks onto the buffer not being written.
    sel_rbuf = (sel_rofs == '0) ? ~wr_buf[sel_ch] : rd_buf[sel_ch];
  end

  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: if (init_done && sel_vld) begin
        grant    = 1'b1;
        state_nx = sel_slot[0] ? RD_BUSY : WR_BUSY;
      end
      WR_BUSY: if (wr_burst_finish) begin
        finish   = 1'b1;
        state_nx = IDLE;
      end
      RD_BUSY: if (rd_burst_finish) begin
        finish   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge phy_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    wr_fifo_rd_en = '0;
    rd_fifo_wr_en = '0;
    if (state == WR_BUSY) wr_fifo_rd_en[gnt_ch] = wr_burst_data_req;
    if (state == RD_BUSY) rd_fifo_wr_en[gnt_ch] = rd_burst_data_valid;
  end

  always_ff @(posedge phy_clk or posedge rst) begin
    if (rst) begin
      rr <= '0; gnt_slot <= '0;
      wr_burst_req <= 1'b0; wr_burst_addr <= '0; wr_burst_len <= '0;
      rd_burst_req <= 1'b0; rd_burst_addr <= '0; rd_burst_len <= '0;
      wr_frame_done <= '0; rd_frame_done <= '0;
      wr_ofs <= '0; rd_ofs <= '0;
      wr_buf <= '0; rd_buf <= '0; frm_valid <= '0; pending <= '0;
    end else begin
      wr_frame_done <= '0;
      rd_frame_done <= '0;
      pending <= pending | frame_restart;
      for (int c = 0; c < CH_NUM; c++) begin
        if (pending[c] && !(busy && gnt_ch == CH_W'(c))) begin
          wr_ofs[c]  <= '0;
          rd_ofs[c]  <= '0;
          pending[c] <= frame_restart[c];
        end
      end
      if (grant) begin
        gnt_slot <= sel_slot;
        rr       <= sel_slot;
        if (sel_slot[0]) begin
          rd_burst_req   <= 1'b1;
          rd_burst_addr  <= mk_addr(sel_ch, sel_rbuf, sel_rofs);
          rd_burst_len   <= LEN_W'(BURST_LEN);
          rd_buf[sel_ch] <= sel_rbuf;
        end else begin
          wr_burst_req  <= 1'b1;
          wr_burst_addr <= mk_addr(sel_ch, wr_buf[sel_ch], sel_wofs);
          wr_burst_len  <= LEN_W'(BURST_LEN);
        end
      end
      if (state == WR_BUSY && wr_burst_data_req)   wr_burst_req <= 1'b0;
      if (state == RD_BUSY && rd_burst_data_valid) rd_burst_req <= 1'b0;
      if (finish) begin
        wr_burst_req <= 1'b0;
        rd_burst_req <= 1'b0;
        // A restart landing with the finish wins: rewind, no done pulse.
        if (pending[gnt_ch] || frame_restart[gnt_ch]) begin
          wr_ofs[gnt_ch]  <= '0;
          rd_ofs[gnt_ch]  <= '0;
          pending[gnt_ch] <= 1'b0;
        end else if (!gnt_rd) begin
          if (wr_ofs[gnt_ch] == OFS_LAST) begin
            wr_ofs[gnt_ch]        <= '0;
            wr_frame_done[gnt_ch] <= 1'b1;
            wr_buf[gnt_ch]        <= ~wr_buf[gnt_ch];
            frm_valid[gnt_ch]     <= 1'b1;
          end else begin
            wr_ofs[gnt_ch] <= wr_ofs[gnt_ch] + OFS_STEP;
          end
        end else begin
          if (rd_ofs[gnt_ch] == OFS_LAST) begin
            rd_ofs[gnt_ch]        <= '0;
            rd_frame_done[gnt_ch] <= 1'b1;
          end else begin
            rd_ofs[gnt_ch] <= rd_ofs[gnt_ch] + OFS_STEP;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ddr_burst_sched.sv
module tb_ddr_burst_sched;
  logic        phy_clk = 1'b0;
  logic        rst, init_done;
  logic [3:0]  wr_req, rd_req, frame_restart;
  logic        wr_burst_req, rd_burst_req;
  logic [24:0] wr_burst_addr, rd_burst_addr;
  logic [9:0]  wr_burst_len, rd_burst_len;
  logic        wr_burst_data_req, wr_burst_finish, rd_burst_data_valid, rd_burst_finish;
  logic [3:0]  wr_fifo_rd_en, rd_fifo_wr_en, wr_frame_done, rd_frame_done;
  logic        ready;

  ddr_burst_sched dut (
    .phy_clk(phy_clk), .rst(rst), .init_done(init_done),
    .wr_req(wr_req), .rd_req(rd_req), .frame_restart(frame_restart),
    .wr_burst_req(wr_burst_req), .wr_burst_addr(wr_burst_addr), .wr_burst_len(wr_burst_len),
    .wr_burst_data_req(wr_burst_data_req), .wr_burst_finish(wr_burst_finish),
    .rd_burst_req(rd_burst_req), .rd_burst_addr(rd_burst_addr), .rd_burst_len(rd_burst_len),
    .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_finish(rd_burst_finish),
    .wr_fifo_rd_en(wr_fifo_rd_en), .rd_fifo_wr_en(rd_fifo_wr_en),
    .wr_frame_done(wr_frame_done), .rd_frame_done(rd_frame_done), .ready(ready)
  );

  always #5 phy_clk = ~phy_clk;

  int n_pass = 0, n_tot = 0, n_to = 0;

  typedef struct {
    logic [3:0]  wr;
    logic [3:0]  rd;
    logic        exp_rd;
    logic [24:0] exp_addr;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_req(output logic to, output int waited);
    waited = 0;
    to = 1'b0;
    while (!(wr_burst_req || rd_burst_req)) begin
      if (waited >= 40) begin
        to = 1'b1;
        return;
      end
      @(negedge phy_clk);
      waited++;
    end
  endtask

  // Engine model: one data strobe, then finish; done pulses sampled after.
  task automatic serve(input logic is_rd, input logic [3:0] rs, output logic [3:0] en,
                       output logic req_after, output logic [3:0] wd, output logic [3:0] rdd);
    if (is_rd) rd_burst_data_valid = 1'b1; else wr_burst_data_req = 1'b1;
    frame_restart = rs;
    #1 en = is_rd ? rd_fifo_wr_en : wr_fifo_rd_en;
    @(negedge phy_clk);
    wr_burst_data_req = 1'b0; rd_burst_data_valid = 1'b0; frame_restart = '0;
    req_after = wr_burst_req | rd_burst_req;
    if (is_rd) rd_burst_finish = 1'b1; else wr_burst_finish = 1'b1;
    @(negedge phy_clk);
    wr_burst_finish = 1'b0; rd_burst_finish = 1'b0;
    wd = wr_frame_done; rdd = rd_frame_done;
  endtask

  task automatic burst(input logic [3:0] rs, output logic is_rd, output logic [24:0] a,
                       output logic [3:0] wd, output logic [3:0] rdd, output logic [3:0] en,
                       output logic req_after, output int waited);
    logic to;
    is_rd = 1'b0; a = '0; wd = '0; rdd = '0; en = '0; req_after = 1'b0;
    wait_req(to, waited);
    if (to) begin
      n_to++;
      return;
    end
    is_rd = rd_burst_req;
    a = is_rd ? rd_burst_addr : wr_burst_addr;
    serve(is_rd, rs, en, req_after, wd, rdd);
  endtask

  initial begin
    logic        r, ra, to;
    logic [24:0] a;
    logic [3:0]  wd, rdd, en;
    int          w, err, ndone, nrd, bad;

    tbl[0] = '{4'b0001, 4'b0000, 1'b0, 25'h0000000};
    tbl[1] = '{4'b0001, 4'b0000, 1'b0, 25'h0000100};
    tbl[2] = '{4'b1111, 4'b0000, 1'b0, 25'h0400000};
    tbl[3] = '{4'b1111, 4'b0000, 1'b0, 25'h0800000};
    tbl[4] = '{4'b1111, 4'b0000, 1'b0, 25'h0C00000};
    tbl[5] = '{4'b1111, 4'b0000, 1'b0, 25'h0000200};
    tbl[6] = '{4'b1111, 4'b1111, 1'b0, 25'h0400100};
    tbl[7] = '{4'b0100, 4'b1111, 1'b0, 25'h0800100};
    tbl[8] = '{4'b1000, 4'b1111, 1'b0, 25'h0C00100};

    rst = 1'b1; init_done = 1'b0; wr_req = '0; rd_req = '0; frame_restart = '0;
    wr_burst_data_req = 0; wr_burst_finish = 0; rd_burst_data_valid = 0; rd_burst_finish = 0;
    repeat (2) @(negedge phy_clk);
    check("reset outputs", {63'd0, |{wr_burst_req, rd_burst_req, wr_burst_addr, rd_burst_addr,
          wr_burst_len, rd_burst_len, wr_fifo_rd_en, rd_fifo_wr_en, wr_frame_done,
          rd_frame_done, ready}}, 64'd0);
    rst = 1'b0;
    init_done = 1'b1;
    @(negedge phy_clk);
    check("ready idle", ready, 1);

    // Round robin and address sequence, one burst per table row.
    for (int i = 0; i < 9; i++) begin
      wr_req = tbl[i].wr; rd_req = tbl[i].rd;
      burst('0, r, a, wd, rdd, en, ra, w);
      if (i == 0) begin
        check("grant latency", w, 1);
        check("wr len", wr_burst_len, 256);
        check("req drop after data", ra, 0);
        check("fifo en ch0", en, 4'b0001);
      end
      check($sformatf("tbl%0d dir", i), r, tbl[i].exp_rd);
      check($sformatf("tbl%0d addr", i), a, tbl[i].exp_addr);
      check($sformatf("tbl%0d done", i), {wd, rdd}, 0);
    end

    // Bring ch2 to offset 0x1000, then restart it mid-burst.
    wr_req = 4'b0100; rd_req = '0; err = 0;
    for (int k = 0; k < 14 && n_to == 0; k++) begin
      burst('0, r, a, wd, rdd, en, ra, w);
      if (a != (25'h0800200 + 25'(k * 256)) || wd != 0) err++;
    end
    check("ch2 walk", err, 0);
    burst(4'b0100, r, a, wd, rdd, en, ra, w);
    check("ch2 burst addr", a, 25'h0801000);
    check("fifo en ch2", en, 4'b0100);
    check("restart no done", wd, 0);
    burst('0, r, a, wd, rdd, en, ra, w);
    check("ch2 after restart", a, 25'h0800000);

    // init_done drop mid-burst: finish the burst, then no grants.
    wr_req = 4'b0001;
    wait_req(to, w);
    if (to) n_to++;
    check("ch0 pre-drop addr", wr_burst_addr, 25'h0000300);
    init_done = 1'b0;
    serve(1'b0, '0, en, ra, wd, rdd);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge phy_clk);
      if (wr_burst_req || rd_burst_req || ready) bad++;
    end
    check("no grant while init low", bad, 0);
    init_done = 1'b1;
    #1 check("ready restored", ready, 1);
    burst('0, r, a, wd, rdd, en, ra, w);
    check("ch0 resume addr", a, 25'h0000400);

    // Restart ch0 while idle so the frame starts at offset 0.
    wr_req = '0;
    @(negedge phy_clk);
    frame_restart = 4'b0001;
    @(negedge phy_clk);
    frame_restart = '0;
    repeat (2) @(negedge phy_clk);

    // Full write frame on ch0 with reads requested but masked.
    wr_req = 4'b0001; rd_req = 4'b0001; err = 0; ndone = 0; nrd = 0;
    for (int k = 0; k < 960 && n_to == 0; k++) begin
      burst('0, r, a, wd, rdd, en, ra, w);
      if (r) nrd++;
      if (a != 25'(k * 256)) err++;
      if (wd[0]) ndone++;
      if (wd[0] != (k == 959)) err++;
    end
    check("frame0 writes", err, 0);
    check("reads masked", nrd, 0);
    check("wr frame done count", ndone, 1);

    burst('0, r, a, wd, rdd, en, ra, w);
    check("first read dir", r, 1);
    check("first read addr", a, 25'h0000000);
    burst('0, r, a, wd, rdd, en, ra, w);
    check("buf1 write dir", r, 0);
    check("buf1 write addr", a, 25'h0200000);

    // Interleaved read frame (buf 0) and write frame (buf 1).
    err = 0; ndone = 0;
    for (int k = 1; k < 960 && n_to == 0; k++) begin
      burst('0, r, a, wd, rdd, en, ra, w);
      if (!r || a != 25'(k * 256) || wd != 0) err++;
      if (rdd[0]) ndone++;
      if (rdd[0] != (k == 959)) err++;
      burst('0, r, a, wd, rdd, en, ra, w);
      if (r || a != (25'h0200000 | 25'(k * 256)) || rdd != 0) err++;
      if (wd[0] != (k == 959)) err++;
    end
    check("read frame sequence", err, 0);
    check("rd frame done count", ndone, 1);

    wr_req = '0; rd_req = '0;
    check("no timeouts", n_to, 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
